// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - shared types for the memory-access pipeline stage
package memory_access_pkg;

    typedef enum logic [1:0] {
        MEM_NONE,
        MEM_LOAD,
        MEM_STORE
    } memory_op_t;

    typedef enum logic [1:0] {
        MEM_BYTE,
        MEM_HALF,
        MEM_WORD
    } memory_mask_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } mem_state_t;

    typedef struct packed {
        logic [31:0]  bits;
        memory_op_t   memory_op;
        memory_mask_t memory_mask;
        logic         memory_sign;
    } instruction_t;

    // address carries the destination register index once a result exists
    typedef struct packed {
        logic        valid;
        logic [4:0]  address;
        logic [31:0] data;
    } data_t;

    typedef struct packed {
        logic         valid;
        logic         ready;
        logic [31:0]  pc;
        instruction_t instruction;
        logic [31:0]  reg_rd1;
        logic [31:0]  reg_rd2;
        data_t        data;
    } stage_status_t;

    function automatic logic [31:0] word_address(input logic [31:0] ea);
        return {ea[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// rtl/memory_access_if.sv - req/ack data-memory port
interface memory_access_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_ready;
    logic [31:0] mem_read_data;

    modport master (
        output mem_req,
        output mem_we,
        output mem_address,
        output mem_write_data,
        output mem_byte_enable,
        input  mem_ready,
        input  mem_read_data
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_address,
        input  mem_write_data,
        input  mem_byte_enable,
        output mem_ready,
        output mem_read_data
    );

endinterface

// File: rtl/memory_access_lanes.sv
// rtl/memory_access_lanes.sv - byte-lane steering for stores and load extraction/extension
module memory_lanes
    import memory_access_pkg::*;
(
    input  logic [1:0]   offset,
    input  memory_mask_t mask,
    input  logic         sign,
    input  logic [31:0]  store_data,
    input  logic [31:0]  raw_word,
    output logic [3:0]   byte_enable,
    output logic [31:0]  write_data,
    output logic [31:0]  load_value
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // store data is replicated across every lane so memory only needs the enables
    always_comb begin
        byte_enable = 4'b1111;
        write_data  = store_data;
        case (mask)
            MEM_BYTE: begin
                byte_enable = 4'b0001 << offset;
                write_data  = {4{store_data[7:0]}};
            end
            MEM_HALF: begin
                byte_enable = 4'b0011 << {offset[1], 1'b0};
                write_data  = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (offset)
            2'd0:    lane_byte = raw_word[7:0];
            2'd1:    lane_byte = raw_word[15:8];
            2'd2:    lane_byte = raw_word[23:16];
            default: lane_byte = raw_word[31:24];
        endcase
        lane_half = offset[1] ? raw_word[31:16] : raw_word[15:0];
        case (mask)
            MEM_BYTE: load_value = {{24{sign & lane_byte[7]}}, lane_byte};
            MEM_HALF: load_value = {{16{sign & lane_half[15]}}, lane_half};
            default:  load_value = raw_word;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory pipeline stage issuing loads/stores over a req/ack port
module memory_access
    import memory_access_pkg::*;
#(
    parameter bit CHECK_STABLE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  stage_status_t          stage_in,
    output stage_status_t          stage_out,
    memory_access_if.master        mem
);

    mem_state_t   state;
    mem_state_t   state_next;

    logic [1:0]   txn_offset;
    memory_mask_t txn_mask;
    logic         txn_sign;
    logic         txn_load;
    logic [31:0]  load_data;

    logic         mem_op;
    logic [1:0]   lane_offset;
    memory_mask_t lane_mask;
    logic         lane_sign;
    logic [3:0]   lane_byte_enable;
    logic [31:0]  lane_write_data;
    logic [31:0]  lane_load_value;

    assign mem_op = stage_in.valid && (stage_in.instruction.memory_op != MEM_NONE);

    // IDLE encodes the incoming store; afterwards the latched fields drive load extraction
    assign lane_offset = (state == IDLE) ? stage_in.data.data[1:0]          : txn_offset;
    assign lane_mask   = (state == IDLE) ? stage_in.instruction.memory_mask : txn_mask;
    assign lane_sign   = (state == IDLE) ? stage_in.instruction.memory_sign : txn_sign;

    memory_lanes u_lanes (
        .offset      (lane_offset),
        .mask        (lane_mask),
        .sign        (lane_sign),
        .store_data  (stage_in.reg_rd2),
        .raw_word    (mem.mem_read_data),
        .byte_enable (lane_byte_enable),
        .write_data  (lane_write_data),
        .load_value  (lane_load_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            mem.mem_req         <= 1'b0;
            mem.mem_we          <= 1'b0;
            mem.mem_address     <= 32'd0;
            mem.mem_write_data  <= 32'd0;
            mem.mem_byte_enable <= 4'd0;
            txn_offset          <= 2'd0;
            txn_mask            <= MEM_BYTE;
            txn_sign            <= 1'b0;
            txn_load            <= 1'b0;
            load_data           <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        mem.mem_req         <= 1'b1;
                        mem.mem_we          <= (stage_in.instruction.memory_op == MEM_STORE);
                        mem.mem_address     <= word_address(stage_in.data.data);
                        mem.mem_write_data  <= lane_write_data;
                        mem.mem_byte_enable <= lane_byte_enable;
                        txn_offset          <= stage_in.data.data[1:0];
                        txn_mask            <= stage_in.instruction.memory_mask;
                        txn_sign            <= stage_in.instruction.memory_sign;
                        txn_load            <= (stage_in.instruction.memory_op == MEM_LOAD);
                    end
                end
                WAIT: begin
                    if (mem.mem_ready) begin
                        mem.mem_req <= 1'b0;
                        load_data   <= lane_load_value;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next      = state;
        stage_out       = stage_in;
        stage_out.ready = 1'b1;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stage_out.valid      = 1'b0;
                    stage_out.data.valid = 1'b0;
                    stage_out.ready      = 1'b0;
                    state_next           = WAIT;
                end
            end
            WAIT: begin
                stage_out.valid      = 1'b0;
                stage_out.data.valid = 1'b0;
                stage_out.ready      = 1'b0;
                if (mem.mem_ready) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                stage_out.valid      = 1'b1;
                stage_out.data.valid = txn_load;
                if (txn_load) begin
                    stage_out.data.data = load_data;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // upstream may only change stage_in across an edge where ready was high
    generate
        if (CHECK_STABLE) begin : g_check_stable
            stage_status_t held_in;
            logic          armed;

            always_ff @(posedge clk) begin
                if (rst) begin
                    armed <= 1'b0;
                end else begin
                    armed <= !stage_out.ready;
                end
                held_in <= stage_in;
                if (!rst && armed) begin
                    assert (stage_in == held_in);
                end
            end
        end
    endgenerate

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipeline stage directly downstream of execute, upstream of writeback.
- Consumes execute's stage_status_t. For loads and stores it runs a req/ack transaction on the data-memory port; every other instruction passes through combinationally.
- Loads return a byte/half/word, sign- or zero-extended, in stage_out.data.data for register writeback.
- Stalls the pipeline via stage_out.ready while a transaction is outstanding.

Parameters:
- CHECK_STABLE, 1, enables simulation assertions that stage_in is held stable while ready=0 (no RTL effect)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- stage_in  input  stage_status_t  from execute
  - data.data = ALU result, used as effective address
  - reg_rd2 = store source
- stage_out  output  stage_status_t  to writeback; ready also back-pressures execute and upstream
- mem_req  output  1  transaction request, registered
- mem_we  output  1  1=store, 0=load, registered
- mem_address  output  32  word-aligned address {ea[31:2],2'b00}, registered
- mem_write_data  output  32  lane-replicated store data, registered
- mem_byte_enable  output  4  active lanes, registered
- mem_ready  input  1  memory ack; read data valid in same cycle
- mem_read_data  input  32  raw word read

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE; mem_req, mem_we, mem_address, mem_write_data, mem_byte_enable and the load-data register all 0.
  - Reset during WAIT abandons the request (mem_req=0 next cycle); memory must tolerate this.
- Memory op is stage_in.valid && instruction.memory_op != MEM_NONE.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no memory op:
  - stage_out mirrors stage_in (valid, pc, instruction, reg_rd1/2, data); ready=1.
  - Zero added latency.
- IDLE, memory op:
  - Output a bubble: stage_out.valid=0, data.valid=0, ready=0.
  - Next edge registers the mem_* outputs, sets mem_req=1, goes to WAIT.
- WAIT:
  - mem_req held and all mem_* outputs held stable; ready=0; stage_out.valid=0.
  - On mem_ready=1, capture mem_read_data, drop mem_req, go to DONE.
  - No timeout.
- DONE (exactly one cycle):
  - stage_out.valid=1 and ready=1, so upstream advances on this edge; next state is IDLE.
  - Load: data.valid=1, data.address=stage_in.data.address (rd index), data.data=extended load value.
  - Store: data.valid=0.
- Minimum memory-op latency is 3 cycles (issue, WAIT with same-cycle ack, DONE); each extra WAIT cycle adds one.
- Lane rules, with o = ea[1:0]:
  - MEM_BYTE: byte_enable = 4'b0001<<o; write_data = {4{rs2[7:0]}}; load = byte o.
  - MEM_HALF: byte_enable = 4'b0011<<{o[1],0}; write_data = {2{rs2[15:0]}}; load = half o[1].
    - ea[0] is ignored (no misalignment trap).
  - MEM_WORD: byte_enable = 4'b1111; ea[1:0] ignored.
  - Loads: memory_sign=1 sign-extends, 0 zero-extends.
  - Store: mem_we=1. Load: mem_we=0; byte_enable is still driven per the size rule.
- Stability: upstream holds stage_in stable while ready=0.
  - The block latches its transaction fields at issue, so mem_* outputs do not depend on stage_in during WAIT.
  - With CHECK_STABLE=1, a change to stage_in while ready=0 fires an assertion.
- Invalid stage_in (valid=0) is never issued, even if memory_op != MEM_NONE.
- A mem_ready pulse in IDLE or DONE is ignored.

Decomposition:
- Shared package:
  - memory_op_t {MEM_NONE, MEM_LOAD, MEM_STORE}
  - memory_mask_t {MEM_BYTE, MEM_HALF, MEM_WORD}
  - instruction fields memory_op, memory_mask, memory_sign
  - mem_state_t {IDLE, WAIT, DONE}
- Sub-module memory_lanes (combinational):
  - ea[1:0] + mask + rs2 -> byte_enable and write_data.
  - raw word + ea[1:0] + mask + sign -> extended load value.
  - Unit-testable on its own.

Test Plan:
- ALU instr (add, rd=5, data=0x1234) in IDLE -> same-cycle stage_out.valid=1, data.valid=1, data.data=0x1234, ready=1, mem_req never rises.
- LB, ea=0x1003, memory_sign=1, memory returns 0x80FFFFFF with ack in the first WAIT cycle:
  - mem_address=0x1000, byte_enable=4'b1000, mem_we=0.
  - DONE 2 cycles after issue with data.data=0xFFFFFF80 and data.valid=1.
- LHU, ea=0x2002, read 0xBEEF0000, ack delayed 4 cycles -> ready=0 for 5 cycles, then DONE with data.data=0x0000BEEF.
- SB, ea=0x3001, rs2=0xAABBCCDD -> mem_we=1, byte_enable=4'b0010, write_data=0xDDDDDDDD; DONE with valid=1, data.valid=0.
- SW with ack withheld, rst pulsed in WAIT -> next cycle mem_req=0, state IDLE, all mem_* outputs=0, ready=1.
- Back-to-back LW 0x10 then LW 0x14, ack immediate:
  - Each issues separately.
  - DONE cycles are 3 apart.
  - No double issue of the first load.
